// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch queue.
// Optional feature macro used by ifetch_queue: IF_PERF_CNT_EN.
package ifetch_pkg;

    // Fetch control FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // may issue a request
        WAIT = 2'd1,    // one request outstanding
        DROP = 2'd2     // outstanding response will be discarded
    } if_state_t;

    // Field width of the entry struct (default XLEN)
    localparam int unsigned IF_XLEN_DEFAULT = 32;

    // One queued fetch result: PC in the upper half, instruction in the lower
    typedef struct packed {
        logic [IF_XLEN_DEFAULT-1:0] pc;
        logic [IF_XLEN_DEFAULT-1:0] instr;
    } if_entry_t;

    // Reset value of the pending-request PC register
    localparam int unsigned IF_RESET_PC = 0;

endpackage : ifetch_pkg

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO with push, pop and clear.
// Storage is registered; the head entry is read combinationally.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy tracking; clear empties the queue without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; zeroed on reset so the head reads 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_clear) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Head and status flags
    always_comb begin
        o_data  = r_mem[r_rptr];
        o_count = r_count;
        o_full  = (r_count == FULL_CNT);
        o_empty = (r_count == '0);
    end

endmodule : ifetch_fifo

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch stage between the program counter and decode.
// Issues one memory request per PC, queues {pc, instr} results in ifetch_fifo,
// and stalls the PC until a request is accepted.
// Optional feature: define IF_PERF_CNT_EN to add the IF_STALL_CNT counter port.
import ifetch_pkg::*;

module ifetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            IF_CLK,
    input  logic            IF_RST_N,
    input  logic [XLEN-1:0] IF_PC,
    output logic            IF_PC_STALL,
    input  logic            IF_FLUSH,
    output logic            IM_REQ,
    output logic [XLEN-1:0] IM_ADDR,
    input  logic            IM_GNT,
    input  logic            IM_RVALID,
    input  logic [XLEN-1:0] IM_RDATA,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_INSTR,
    output logic [XLEN-1:0] ID_PC,
    input  logic            ID_READY
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     IF_STALL_CNT
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if_state_t        r_state;
    logic [XLEN-1:0]  r_pend_pc;

    logic             w_req;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [2*XLEN-1:0] w_push_data;
    logic [2*XLEN-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;

    // Request, stall and FIFO control; flush overrides request, push and pop
    always_comb begin
        w_req       = IF_RST_N && (r_state == IDLE) && (w_count < FULL_CNT) && !IF_FLUSH;
        w_accept    = w_req && IM_GNT;
        w_push      = (r_state == WAIT) && IM_RVALID && !IF_FLUSH;
        w_pop       = !w_empty && ID_READY && !IF_FLUSH;
        w_push_data = {r_pend_pc, IM_RDATA};
        IM_REQ      = w_req;
        IM_ADDR     = IF_PC;
        IF_PC_STALL = !w_accept;
        ID_VALID    = !w_empty;
        ID_PC       = w_head[2*XLEN-1:XLEN];
        ID_INSTR    = w_head[XLEN-1:0];
    end

    // Fetch FSM and pending-request PC
    always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
        if (!IF_RST_N) begin
            r_state   <= IDLE;
            r_pend_pc <= XLEN'(IF_RESET_PC);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pend_pc <= IF_PC;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (IM_RVALID) begin
                        r_state <= IDLE;
                    end else if (IF_FLUSH) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    // The stale response always retires the request, even under a new flush
                    if (IM_RVALID) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (IF_CLK),
        .rst_n   (IF_RST_N),
        .i_clear (IF_FLUSH),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A push into a full FIFO would mean the slot reservation is broken
    a_no_overflow: assert property (@(posedge IF_CLK) disable iff (!IF_RST_N)
        !(w_full && w_push && !w_pop));

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles in which the PC is held; wraps, unaffected by flush
    always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
        if (!IF_RST_N) begin
            r_stall_cnt <= '0;
        end else if (IF_PC_STALL) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign IF_STALL_CNT = r_stall_cnt;
`endif

endmodule : ifetch_queue

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue (DEPTH=2, XLEN=32).
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pc_stall;
    logic        flush;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int tests_run = 0;
    int fails     = 0;

    ifetch_queue #(
        .DEPTH (2),
        .XLEN  (32)
    ) dut (
        .IF_CLK       (clk),
        .IF_RST_N     (rst_n),
        .IF_PC        (if_pc),
        .IF_PC_STALL  (pc_stall),
        .IF_FLUSH     (flush),
        .IM_REQ       (im_req),
        .IM_ADDR      (im_addr),
        .IM_GNT       (im_gnt),
        .IM_RVALID    (im_rvalid),
        .IM_RDATA     (im_rdata),
        .ID_VALID     (id_valid),
        .ID_INSTR     (id_instr),
        .ID_PC        (id_pc),
        .ID_READY     (id_ready)
`ifdef IF_PERF_CNT_EN
        ,
        .IF_STALL_CNT (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here, checks follow #1 later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", im_req); end
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", id_valid); end
        tests_run++; if (id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", id_instr); end
        tests_run++; if (id_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", id_pc); end
        tests_run++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b exp 1", pc_stall); end
    endtask

    task automatic test_first_fetch();
        cyc();
        rst_n = 1'b1; if_pc = 32'h0; im_gnt = 1'b1;
        #1;
        tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL first_req got %b exp 1", im_req); end
        tests_run++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL first_stall got %b exp 0", pc_stall); end
        cyc();                      // grant edge (cycle 0)
        im_gnt = 1'b0; if_pc = 32'h4; im_rvalid = 1'b1; im_rdata = 32'h0000_0013;
        #1;
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL first_wait_req got %b exp 0", im_req); end
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL first_early_valid got %b exp 0", id_valid); end
        cyc();                      // response edge (cycle 1)
        im_rvalid = 1'b0;
        #1;
        tests_run++; if (id_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", id_valid); end
        tests_run++; if (id_pc !== 32'h0) begin fails++; $display("FAIL first_pc got %h exp 0", id_pc); end
        tests_run++; if (id_instr !== 32'h0000_0013) begin fails++; $display("FAIL first_instr got %h exp 00000013", id_instr); end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL first_pop_valid got %b exp 0", id_valid); end
    endtask

    task automatic test_gnt_stall();
        if_pc = 32'h4; im_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL gnt_stall[%0d] got %b exp 1", i, pc_stall); end
            tests_run++; if (im_addr !== 32'h4) begin fails++; $display("FAIL gnt_addr[%0d] got %h exp 4", i, im_addr); end
            tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL gnt_req[%0d] got %b exp 1", i, im_req); end
            cyc();
        end
        im_gnt = 1'b1;
        #1;
        tests_run++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL gnt_release got %b exp 0", pc_stall); end
        cyc();
        im_gnt = 1'b0; if_pc = 32'h8; im_rvalid = 1'b1; im_rdata = 32'h0040_0093;
        #1;
        tests_run++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL gnt_one_cycle got %b exp 1", pc_stall); end
        cyc();
        im_rvalid = 1'b0;
        #1;
        tests_run++; if (id_pc !== 32'h4) begin fails++; $display("FAIL gnt_pc got %h exp 4", id_pc); end
        tests_run++; if (id_instr !== 32'h0040_0093) begin fails++; $display("FAIL gnt_instr got %h exp 00400093", id_instr); end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
    endtask

    task automatic test_full();
        if_pc = 32'h8; im_gnt = 1'b1;
        cyc();                      // accept 0x8
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hA000_0008;
        cyc();                      // push 0x8
        im_rvalid = 1'b0; if_pc = 32'hC; im_gnt = 1'b1;
        #1;
        tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL full_req_one got %b exp 1", im_req); end
        cyc();                      // accept 0xC
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hA000_000C;
        cyc();                      // push 0xC, FIFO full
        im_rvalid = 1'b0; if_pc = 32'h10; im_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL full_req[%0d] got %b exp 0", i, im_req); end
            tests_run++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL full_stall[%0d] got %b exp 1", i, pc_stall); end
            cyc();
        end
        id_ready = 1'b1;
        #1;
        tests_run++; if (id_pc !== 32'h8) begin fails++; $display("FAIL full_head0 got %h exp 8", id_pc); end
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL full_pop_req got %b exp 0", im_req); end
        cyc();                      // pop 0x8
        id_ready = 1'b0;
        #1;
        tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL full_reenable got %b exp 1", im_req); end
        tests_run++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL full_unstall got %b exp 0", pc_stall); end
        tests_run++; if (id_pc !== 32'hC) begin fails++; $display("FAIL full_head1 got %h exp c", id_pc); end
        cyc();                      // accept 0x10
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hA000_0010;
        cyc();                      // push 0x10
        im_rvalid = 1'b0; id_ready = 1'b1;
        #1;
        tests_run++; if (id_instr !== 32'hA000_000C) begin fails++; $display("FAIL full_order0 got %h exp a000000c", id_instr); end
        cyc();
        #1;
        tests_run++; if (id_pc !== 32'h10) begin fails++; $display("FAIL full_order1_pc got %h exp 10", id_pc); end
        tests_run++; if (id_instr !== 32'hA000_0010) begin fails++; $display("FAIL full_order1_instr got %h exp a0000010", id_instr); end
        cyc();
        id_ready = 1'b0;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL full_drained got %b exp 0", id_valid); end
    endtask

    task automatic test_flush_wait();
        if_pc = 32'h14; im_gnt = 1'b1;
        cyc();                      // accept 0x14
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h0000_0014;
        cyc();                      // push 0x14
        im_rvalid = 1'b0; if_pc = 32'h18; im_gnt = 1'b1;
        cyc();                      // accept 0x18 -> WAIT with one entry queued
        im_gnt = 1'b0; flush = 1'b1;
        #1;
        tests_run++; if (id_valid !== 1'b1) begin fails++; $display("FAIL flushw_pre_valid got %b exp 1", id_valid); end
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL flushw_req got %b exp 0", im_req); end
        cyc();                      // flush edge -> DROP
        flush = 1'b0; if_pc = 32'h40; im_gnt = 1'b1;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flushw_valid got %b exp 0", id_valid); end
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL flushw_drop_req got %b exp 0", im_req); end
        tests_run++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL flushw_drop_stall got %b exp 1", pc_stall); end
        cyc();
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF;
        cyc();                      // stale response discarded
        im_rvalid = 1'b0; im_gnt = 1'b1;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flushw_stale got %b exp 0", id_valid); end
        tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL flushw_new_req got %b exp 1", im_req); end
        tests_run++; if (im_addr !== 32'h40) begin fails++; $display("FAIL flushw_new_addr got %h exp 40", im_addr); end
        cyc();                      // accept 0x40
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h4040_4040;
        cyc();
        im_rvalid = 1'b0;
        #1;
        tests_run++; if (id_pc !== 32'h40) begin fails++; $display("FAIL flushw_new_pc got %h exp 40", id_pc); end
        tests_run++; if (id_instr !== 32'h4040_4040) begin fails++; $display("FAIL flushw_new_instr got %h exp 40404040", id_instr); end
    endtask

    task automatic test_flush_rvalid();
        // One entry (0x40) is still queued
        if_pc = 32'h44; im_gnt = 1'b1;
        cyc();                      // accept 0x44
        im_gnt = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h0000_0055; flush = 1'b1; id_ready = 1'b1;
        #1;
        tests_run++; if (im_req !== 1'b0) begin fails++; $display("FAIL flushr_req got %b exp 0", im_req); end
        cyc();
        im_rvalid = 1'b0; flush = 1'b0; id_ready = 1'b0;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flushr_valid got %b exp 0", id_valid); end
        tests_run++; if (im_req !== 1'b1) begin fails++; $display("FAIL flushr_idle_req got %b exp 1", im_req); end
        cyc();
        #1;
        tests_run++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flushr_no_push got %b exp 0", id_valid); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf_cnt();
        im_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL perf_reset0 got %0d exp 0", stall_cnt); end
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        tests_run++; if (stall_cnt !== 32'd5) begin fails++; $display("FAIL perf_count got %0d exp 5", stall_cnt); end
        repeat (2) cyc();
        rst_n = 1'b0;
        #1;
        tests_run++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL perf_async_reset got %0d exp 0", stall_cnt); end
        cyc();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; if_pc = '0; flush = 1'b0; im_gnt = 1'b0;
        im_rvalid = 1'b0; im_rdata = '0; id_ready = 1'b0;
        repeat (2) cyc();
        test_reset();
        test_first_fetch();
        test_gnt_stall();
        test_full();
        test_flush_wait();
        test_flush_rvalid();
`ifdef IF_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_ifetch_queue

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch stage that sits directly downstream of the program counter and upstream of decode. It issues one instruction-memory/I-cache request per PC value, buffers returned instructions with their PCs in a small FIFO, and presents them to decode with a valid/ready handshake. It drives the program counter's stall input, so the PC advances only when a fetch request is accepted. Branch/jump flushes discard queued and in-flight instructions.

## Interface
- `DEPTH`, 2: FIFO entries; legal values are 2 or 4.
- `XLEN`, 32: address and instruction width.

- `IF_CLK`  in  1  clock; all state updates on the rising edge.
- `IF_RST_N`  in  1  reset; asynchronous, active-low.
- `IF_PC`  in  XLEN  current `PC_COUNT` from the program counter.
- `IF_PC_STALL`  out  1  to the program counter's `PC_S_STALL`; 1 = PC holds.
- `IF_FLUSH`  in  1  taken branch/jump; discard all fetched work.
- `IM_REQ`  out  1  fetch request valid.
- `IM_ADDR`  out  XLEN  fetch address, equal to `IF_PC`.
- `IM_GNT`  in  1  memory/cache accepts the request this cycle.
- `IM_RVALID`  in  1  read data valid.
- `IM_RDATA`  in  XLEN  instruction word.
- `ID_VALID`  out  1  FIFO head valid toward decode.
- `ID_INSTR`  out  XLEN  FIFO head instruction.
- `ID_PC`  out  XLEN  FIFO head PC.
- `ID_READY`  in  1  decode consumes the head this cycle.
- `IF_STALL_CNT`  out  32  stall-cycle counter; present only with `IF_PERF_CNT_EN`.

## Operation
- FSM states:
  - `IDLE`: may request.
  - `WAIT`: one request is outstanding.
  - `DROP`: the outstanding response is discarded.
- Space rule: `IM_REQ` = state `IDLE` and `count < DEPTH` and not `IF_FLUSH`. This reserves a slot for the outstanding response, so a push never overflows.
- Grant in `IDLE`:
  - Request accepted when `IM_REQ && IM_GNT`.
  - Latch `IF_PC` into `pend_pc`; go to `WAIT`.
- Response in `WAIT`:
  - On `IM_RVALID`, push `{pend_pc, IM_RDATA}`; go to `IDLE`.
  - No new request is issued in the same cycle.
- PC stall: `IF_PC_STALL` = not (`IM_REQ && IM_GNT`), combinational. The PC loads its next value exactly on the accept edge.
- Pop: when `ID_VALID && ID_READY`. Push and pop in the same cycle leave `count` unchanged.
- Flush; `IF_FLUSH` has priority over push, pop and request:
  - FIFO is cleared in every state.
  - `IDLE` stays `IDLE` with no request that cycle.
  - `WAIT` without `IM_RVALID` goes to `DROP`.
  - `WAIT` with `IM_RVALID` discards the data and goes to `IDLE`.
  - `DROP` stays `DROP`.
- `DROP`: the next `IM_RVALID` is discarded, not pushed; go to `IDLE`.
- Ignored inputs: `IM_RVALID` in `IDLE` is ignored; the bench must never drive it.
- Reset values (asynchronous):
  - State `IDLE`, `count` 0, pointers 0, `pend_pc` 0.
  - `ID_VALID` 0, `ID_INSTR` 0, `ID_PC` 0.
  - `IM_REQ` 0 while `IF_RST_N` is low.
  - `IF_STALL_CNT` 0.
- Reset mid-operation: an outstanding request is abandoned. The memory side must also reset.

## Timing
- Request issued and granted in cycle 0; `IM_RVALID` arrives in cycle N≥1.
- The entry is visible on `ID_VALID`/`ID_INSTR`/`ID_PC` in cycle N+1, because FIFO storage is registered and the head is read combinationally from registers.
- Best-case throughput is one instruction per 2 cycles (zero-wait memory with `RVALID` one cycle after `GNT`).
- Wrap-around: read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- Full FIFO (`count == DEPTH`): `IM_REQ` is 0 and `IF_PC_STALL` is 1 until a pop.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `IF_STALL_CNT` increments by 1 every cycle with `IF_PC_STALL` = 1 and `IF_RST_N` high.
  - Wraps at 2^32; not cleared by flush.
- `IF_PERF_CNT_EN` undefined: the port and counter logic are absent.

## Structure
- Shared package `ifetch_pkg`:
  - FSM enum `if_state_t` {`IDLE`, `WAIT`, `DROP`}.
  - Packed struct `if_entry_t` {`pc`, `instr`}.
  - Localparam `IF_RESET_PC` = 0.
- One sub-module: `ifetch_fifo`, a DEPTH-entry synchronous FIFO with push, pop and clear, plus `count`/`full`/`empty`.
- The FSM, request logic and stall logic live in the top module.

## Test plan
- Reset release with `IF_PC`=0x0 and `IM_GNT`=1: `IM_REQ`=1 in the first cycle, `IF_PC_STALL`=0. With RVALID after 1 cycle and `IM_RDATA`=0x00000013, `ID_PC`=0x0 and `ID_INSTR`=0x00000013 are valid two cycles after grant.
- `IM_GNT` held 0 for 3 cycles at PC 0x4: `IF_PC_STALL`=1 for all 3 cycles and `IM_ADDR` stable at 0x4. The grant in cycle 4 drops stall for exactly one cycle.
- `ID_READY`=0 while 2 fetches (PC 0x8, 0xC) complete with DEPTH=2: `IM_REQ`=0 and stall=1. A single pop of 0x8 re-enables the request the next cycle, and order is preserved (0xC then the new PC).
- `IF_FLUSH` while in `WAIT` with 1 queued entry: `ID_VALID`=0 the next cycle. The late `IM_RVALID` (data 0xDEADBEEF) is never seen on the ID outputs, and the next request goes to the new `IF_PC`.
- `IF_FLUSH` coincident with `IM_RVALID` and an `ID_READY` pop: FIFO empty and state `IDLE` next cycle, with no push.
- With `IF_PERF_CNT_EN` defined: after 5 stalled cycles `IF_STALL_CNT`=5; asserting `IF_RST_N`=0 mid-count returns it to 0 immediately.
